// File: rtl/rec_auto_cmd_gen_if.sv
// Command bus between the receiver decoder / flight-mode controller and
// rec_auto_cmd_gen. The master drives the select and raw stick values, the
// slave returns the commanded sticks and status flags.
interface rec_auto_cmd_gen_if;
  logic [2:0] rec_data_sel;
  logic [7:0] rx_throttle_val;
  logic [7:0] rx_yaw_val;
  logic [7:0] rx_roll_val;
  logic [7:0] rx_pitch_val;
  logic [7:0] throttle_val;
  logic [7:0] yaw_val;
  logic [7:0] roll_val;
  logic [7:0] pitch_val;
  logic       auto_active;
  logic       takeoff_done;
  logic       land_done;
  logic       sel_err;

  modport master (
    output rec_data_sel, rx_throttle_val, rx_yaw_val, rx_roll_val, rx_pitch_val,
    input  throttle_val, yaw_val, roll_val, pitch_val,
    input  auto_active, takeoff_done, land_done, sel_err
  );

  modport slave (
    input  rec_data_sel, rx_throttle_val, rx_yaw_val, rx_roll_val, rx_pitch_val,
    output throttle_val, yaw_val, roll_val, pitch_val,
    output auto_active, takeoff_done, land_done, sel_err
  );
endinterface

// File: rtl/rec_auto_cmd_gen.sv
// rec_auto_cmd_gen: per-mode stick command source for the angle controller.
// Passes raw receiver sticks through, or generates throttle ramps for auto
// take-off / auto-land and a hover-throttle hold, with attitude centred.
// Optional feature macro: REC_AUTO_PASS_SLEW_EN (slew-limits PASS throttle).
module rec_auto_cmd_gen #(
  parameter logic [7:0]  HOVER_THROTTLE = 8'd140,
  parameter logic [7:0]  STICK_CENTER   = 8'd125,
  parameter int unsigned RAMP_TICK_US   = 10000,
  parameter logic [7:0]  RAMP_STEP      = 8'd1
`ifdef REC_AUTO_PASS_SLEW_EN
  , parameter logic [7:0] SLEW_MAX      = 8'd4
`endif
) (
  input logic               us_clk,
  input logic               reset,
  rec_auto_cmd_gen_if.slave bus
);

  localparam int unsigned      CNT_W     = (RAMP_TICK_US > 1) ? $clog2(RAMP_TICK_US) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(RAMP_TICK_US - 1);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PASS    = 3'd1,
    ST_TAKEOFF = 3'd2,
    ST_HOVER   = 3'd3,
    ST_LAND    = 3'd4
  } state_t;

  state_t           state;
  state_t           nxt_state;
  logic [CNT_W-1:0] tick_cnt;
  logic [7:0]       thr_q;
  logic [7:0]       yaw_q;
  logic [7:0]       roll_q;
  logic [7:0]       pitch_q;
  logic             auto_q;
  logic             to_done_q;
  logic             ld_done_q;
  logic             err_q;

  logic             sel_bad;
  logic             state_chg;
  logic             tick;
  logic [8:0]       up_sum;
  logic [8:0]       hov_lim;
  logic [7:0]       up_val;
  logic [7:0]       dn_val;
  logic [7:0]       hover_val;
  logic [7:0]       pass_thr;
  logic [7:0]       thr_nxt;

  // Decode the select code; invalid codes fall back to OFF and flag an error
  always_comb begin
    nxt_state = ST_OFF;
    sel_bad   = 1'b0;
    case (bus.rec_data_sel)
      3'd0:    nxt_state = ST_OFF;
      3'd1:    nxt_state = ST_PASS;
      3'd2:    nxt_state = ST_TAKEOFF;
      3'd3:    nxt_state = ST_HOVER;
      3'd4:    nxt_state = ST_LAND;
      default: sel_bad   = 1'b1;
    endcase
  end

  // A mode change suppresses the step that would otherwise fire this cycle
  assign state_chg = (nxt_state != state);
  assign tick      = !state_chg && (tick_cnt == TICK_LAST);

  // Saturating ramp candidates, computed 9-bit so nothing wraps
  always_comb begin
    up_sum  = {1'b0, thr_q} + {1'b0, RAMP_STEP};
    hov_lim = {1'b0, HOVER_THROTTLE} + {1'b0, RAMP_STEP};
    up_val  = (up_sum > {1'b0, HOVER_THROTTLE}) ? HOVER_THROTTLE : up_sum[7:0];
    dn_val  = (thr_q > RAMP_STEP) ? (thr_q - RAMP_STEP) : 8'd0;
    if (thr_q < HOVER_THROTTLE) begin
      hover_val = up_val;
    end else if ({1'b0, thr_q} > hov_lim) begin
      hover_val = thr_q - RAMP_STEP;
    end else begin
      hover_val = HOVER_THROTTLE;
    end
  end

`ifdef REC_AUTO_PASS_SLEW_EN
  logic [7:0] slew_diff;

  // PASS throttle chases the receiver by at most SLEW_MAX per tick
  always_comb begin
    pass_thr  = thr_q;
    slew_diff = 8'd0;
    if (tick) begin
      if (bus.rx_throttle_val > thr_q) begin
        slew_diff = bus.rx_throttle_val - thr_q;
        pass_thr  = (slew_diff > SLEW_MAX) ? (thr_q + SLEW_MAX) : bus.rx_throttle_val;
      end else begin
        slew_diff = thr_q - bus.rx_throttle_val;
        pass_thr  = (slew_diff > SLEW_MAX) ? (thr_q - SLEW_MAX) : bus.rx_throttle_val;
      end
    end
  end
`else
  // PASS throttle is a straight registered copy of the receiver
  assign pass_thr = bus.rx_throttle_val;
`endif

  // Throttle for the mode being entered/held; auto modes step only on tick
  always_comb begin
    thr_nxt = thr_q;
    case (nxt_state)
      ST_OFF:     thr_nxt = 8'd0;
      ST_PASS:    thr_nxt = pass_thr;
      ST_TAKEOFF: if (tick) thr_nxt = up_val;
      ST_HOVER:   if (tick) thr_nxt = hover_val;
      ST_LAND:    if (tick) thr_nxt = dn_val;
      default:    thr_nxt = 8'd0;
    endcase
  end

  // Mode register, tick prescaler and registered outputs/flags
  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_OFF;
      tick_cnt  <= '0;
      thr_q     <= 8'd0;
      yaw_q     <= STICK_CENTER;
      roll_q    <= STICK_CENTER;
      pitch_q   <= STICK_CENTER;
      auto_q    <= 1'b0;
      to_done_q <= 1'b0;
      ld_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= nxt_state;
      tick_cnt  <= (state_chg || tick) ? '0 : tick_cnt + CNT_W'(1);
      thr_q     <= thr_nxt;
      case (nxt_state)
        ST_PASS: begin
          yaw_q   <= bus.rx_yaw_val;
          roll_q  <= bus.rx_roll_val;
          pitch_q <= bus.rx_pitch_val;
        end
        default: begin
          yaw_q   <= STICK_CENTER;
          roll_q  <= STICK_CENTER;
          pitch_q <= STICK_CENTER;
        end
      endcase
      auto_q    <= (nxt_state == ST_TAKEOFF) || (nxt_state == ST_HOVER) ||
                   (nxt_state == ST_LAND);
      to_done_q <= (nxt_state == ST_TAKEOFF) && (thr_nxt == HOVER_THROTTLE);
      ld_done_q <= (nxt_state == ST_LAND) && (thr_nxt == 8'd0);
      if (sel_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.throttle_val = thr_q;
  assign bus.yaw_val      = yaw_q;
  assign bus.roll_val     = roll_q;
  assign bus.pitch_val    = pitch_q;
  assign bus.auto_active  = auto_q;
  assign bus.takeoff_done = to_done_q;
  assign bus.land_done    = ld_done_q;
  assign bus.sel_err      = err_q;

endmodule

// File: tb/tb_rec_auto_cmd_gen.sv
// Testbench for rec_auto_cmd_gen: two instances (RAMP_STEP 1 and 3, 4-cycle
// tick) share one randomized stimulus stream and are compared every cycle
// against a mode/age based reference model, plus directed scenario checks.
module tb_rec_auto_cmd_gen;

  localparam int TICK   = 4;
  localparam int HOVER  = 140;
  localparam int CENTER = 125;
`ifdef REC_AUTO_PASS_SLEW_EN
  localparam int SLEW       = 4;
  localparam int PASS_SETTLE = 300;
`else
  localparam int PASS_SETTLE = 1;
`endif
  localparam logic [35:0] RST_VEC = {8'd0, 8'd125, 8'd125, 8'd125, 4'b0000};

  logic       us_clk = 1'b0;
  logic       reset;
  logic [2:0] sel;
  logic [7:0] rx_t, rx_y, rx_r, rx_p;

  rec_auto_cmd_gen_if bus1 ();
  rec_auto_cmd_gen_if bus3 ();

  assign bus1.rec_data_sel    = sel;
  assign bus1.rx_throttle_val = rx_t;
  assign bus1.rx_yaw_val      = rx_y;
  assign bus1.rx_roll_val     = rx_r;
  assign bus1.rx_pitch_val    = rx_p;
  assign bus3.rec_data_sel    = sel;
  assign bus3.rx_throttle_val = rx_t;
  assign bus3.rx_yaw_val      = rx_y;
  assign bus3.rx_roll_val     = rx_r;
  assign bus3.rx_pitch_val    = rx_p;

  rec_auto_cmd_gen #(.RAMP_TICK_US(TICK), .RAMP_STEP(8'd1)) dut1 (
    .us_clk (us_clk),
    .reset  (reset),
    .bus    (bus1.slave)
  );

  rec_auto_cmd_gen #(.RAMP_TICK_US(TICK), .RAMP_STEP(8'd3)) dut3 (
    .us_clk (us_clk),
    .reset  (reset),
    .bus    (bus3.slave)
  );

  always #5 us_clk = ~us_clk;

  logic [35:0] obs1, obs3;
  assign obs1 = {bus1.throttle_val, bus1.yaw_val, bus1.roll_val, bus1.pitch_val,
                 bus1.auto_active, bus1.takeoff_done, bus1.land_done, bus1.sel_err};
  assign obs3 = {bus3.throttle_val, bus3.yaw_val, bus3.roll_val, bus3.pitch_val,
                 bus3.auto_active, bus3.takeoff_done, bus3.land_done, bus3.sel_err};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  // Reference model: mode, cycles spent in the mode, and commanded values
  int m_step  [2];
  int m_mode  [2];
  int m_age   [2];
  int m_thr   [2];
  int m_yaw   [2];
  int m_roll  [2];
  int m_pitch [2];
  bit m_err   [2];

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", tag, obs, exp, cyc_n, $time);
    end
  endtask

  task automatic mdl_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k]  = 0;
      m_age[k]   = 0;
      m_thr[k]   = 0;
      m_yaw[k]   = CENTER;
      m_roll[k]  = CENTER;
      m_pitch[k] = CENTER;
      m_err[k]   = 1'b0;
    end
  endtask

  // One clock edge of behaviour, from the inputs present at that edge
  task automatic mdl_step();
    for (int k = 0; k < 2; k++) begin
      int mode_new;
      bit tk;
      mode_new = (sel > 3'd4) ? 0 : int'(sel);
      if (sel > 3'd4) m_err[k] = 1'b1;
      if (mode_new != m_mode[k]) begin
        m_mode[k] = mode_new;
        m_age[k]  = 0;
        tk        = 1'b0;
      end else begin
        m_age[k]++;
        tk = (m_age[k] % TICK) == 0;
      end
      m_yaw[k]   = CENTER;
      m_roll[k]  = CENTER;
      m_pitch[k] = CENTER;
      case (m_mode[k])
        0: m_thr[k] = 0;
        1: begin
          m_yaw[k]   = int'(rx_y);
          m_roll[k]  = int'(rx_r);
          m_pitch[k] = int'(rx_p);
`ifdef REC_AUTO_PASS_SLEW_EN
          if (tk) begin
            if (int'(rx_t) - m_thr[k] > SLEW)      m_thr[k] += SLEW;
            else if (m_thr[k] - int'(rx_t) > SLEW) m_thr[k] -= SLEW;
            else                                   m_thr[k] = int'(rx_t);
          end
`else
          m_thr[k] = int'(rx_t);
`endif
        end
        2: if (tk) m_thr[k] = (m_thr[k] + m_step[k] > HOVER) ? HOVER : m_thr[k] + m_step[k];
        3: if (tk) begin
          if (m_thr[k] < HOVER)
            m_thr[k] = (m_thr[k] + m_step[k] > HOVER) ? HOVER : m_thr[k] + m_step[k];
          else
            m_thr[k] = (m_thr[k] - m_step[k] < HOVER) ? HOVER : m_thr[k] - m_step[k];
        end
        default: if (tk) m_thr[k] = (m_thr[k] > m_step[k]) ? m_thr[k] - m_step[k] : 0;
      endcase
    end
  endtask

  function automatic logic [35:0] mdl_vec(input int k);
    logic a, td, ld;
    a  = (m_mode[k] >= 2);
    td = (m_mode[k] == 2) && (m_thr[k] == HOVER);
    ld = (m_mode[k] == 4) && (m_thr[k] == 0);
    return {m_thr[k][7:0], m_yaw[k][7:0], m_roll[k][7:0], m_pitch[k][7:0], a, td, ld, m_err[k]};
  endfunction

  // Advance one clock, update the model, compare both instances at negedge
  task automatic cyc();
    @(posedge us_clk);
    if (!reset) mdl_step();
    @(negedge us_clk);
    cyc_n++;
    chk("model_s1", obs1, mdl_vec(0));
    chk("model_s3", obs3, mdl_vec(1));
  endtask

  task automatic set_in(input logic [2:0] s, input logic [7:0] t);
    sel  = s;
    rx_t = t;
    rx_y = 8'($urandom);
    rx_r = 8'($urandom);
    rx_p = 8'($urandom);
  endtask

  task automatic goto_pass(input logic [7:0] t);
    set_in(3'd1, t);
    repeat (PASS_SETTLE) cyc();
  endtask

  initial begin
    m_step[0] = 1;
    m_step[1] = 3;
    reset = 1'b1;
    sel   = 3'd0;
    rx_t  = 8'd0;
    rx_y  = 8'd0;
    rx_r  = 8'd0;
    rx_p  = 8'd0;
    mdl_reset();
    #1;
    chk("reset_s1", obs1, RST_VEC);
    chk("reset_s3", obs3, RST_VEC);
    repeat (2) cyc();
    reset = 1'b0;
    repeat (2) cyc();

    // Pass-through
    sel = 3'd1; rx_t = 8'd90; rx_y = 8'd10; rx_r = 8'd200; rx_p = 8'd33;
    cyc();
`ifndef REC_AUTO_PASS_SLEW_EN
    chk("pass_thr", 36'(bus1.throttle_val), 36'd90);
`endif
    chk("pass_att", 36'({bus1.yaw_val, bus1.roll_val, bus1.pitch_val}), 36'({8'd10, 8'd200, 8'd33}));
    chk("pass_auto", 36'(bus1.auto_active), 36'd0);

    // Take-off ramp from 135 (step 1)
    goto_pass(8'd135);
    set_in(3'd2, 8'd0);
    cyc();
    chk("to_entry", 36'(bus1.throttle_val), 36'd135);
    repeat (4) cyc();
    chk("to_tick1", 36'(bus1.throttle_val), 36'd136);
    repeat (16) cyc();
    chk("to_tick5", 36'(bus1.throttle_val), 36'd140);
    chk("to_done", 36'(bus1.takeoff_done), 36'd1);
    repeat (20) cyc();
    chk("to_hold", 36'(bus1.throttle_val), 36'd140);
    chk("to_done_hold", 36'(bus1.takeoff_done), 36'd1);

    // Land ramp from 7 (step 3)
    goto_pass(8'd7);
    set_in(3'd4, 8'd0);
    cyc();
    repeat (4) cyc();
    chk("land_tick1", 36'(bus3.throttle_val), 36'd4);
    repeat (4) cyc();
    chk("land_tick2", 36'(bus3.throttle_val), 36'd1);
    repeat (4) cyc();
    chk("land_tick3", 36'(bus3.throttle_val), 36'd0);
    chk("land_done3", 36'(bus3.land_done), 36'd1);
    repeat (28) cyc();
    chk("land_nowrap", 36'(bus3.throttle_val), 36'd0);
    chk("land_done10", 36'(bus3.land_done), 36'd1);

    // Hover convergence from above, then invalid code
    goto_pass(8'd150);
    set_in(3'd3, 8'd0);
    cyc();
    repeat (20) cyc();
    chk("hover_mid", 36'(bus1.throttle_val), 36'd145);
    repeat (20) cyc();
    chk("hover_tgt", 36'(bus1.throttle_val), 36'd140);
    repeat (20) cyc();
    chk("hover_stop", 36'(bus1.throttle_val), 36'd140);
    set_in(3'd6, 8'd77);
    cyc();
    chk("inv_state", obs1, {8'd0, 8'd125, 8'd125, 8'd125, 4'b0001});
    set_in(3'd1, 8'd77);
    cyc();
    chk("inv_sticky", 36'(bus1.sel_err), 36'd1);

    // Asynchronous reset mid-land at throttle 60
    goto_pass(8'd60);
    set_in(3'd4, 8'd0);
    cyc();
    cyc();
    chk("pre_rst_thr", 36'(bus1.throttle_val), 36'd60);
    #2 reset = 1'b1;
    #1;
    mdl_reset();
    chk("rst_async_s1", obs1, RST_VEC);
    chk("rst_async_s3", obs3, RST_VEC);
    sel = 3'd0;
    repeat (2) cyc();
    reset = 1'b0;
    repeat (3) cyc();
    chk("rst_release", obs1, RST_VEC);

    // PASS throttle step response from 0 to 20
    set_in(3'd0, 8'd0);
    cyc();
    set_in(3'd1, 8'd20);
    cyc();
`ifdef REC_AUTO_PASS_SLEW_EN
    chk("slew_entry", 36'(bus1.throttle_val), 36'd0);
    for (int i = 1; i <= 5; i++) begin
      repeat (TICK) cyc();
      chk("slew_step", 36'(bus1.throttle_val), 36'(4 * i));
    end
`else
    chk("pass_step", 36'(bus1.throttle_val), 36'd20);
`endif

    // Randomized mode sequences with occasional asynchronous reset
    for (int seg = 0; seg < 150; seg++) begin
      int r, dur;
      logic [2:0] s;
      r   = int'($urandom_range(0, 19));
      s   = (r < 2) ? 3'(5 + $urandom_range(0, 2)) : 3'($urandom_range(0, 4));
      dur = int'($urandom_range(1, 50));
      for (int d = 0; d < dur; d++) begin
        set_in(s, 8'($urandom));
        if ($urandom_range(0, 299) == 0) begin
          #2 reset = 1'b1;
          mdl_reset();
          cyc();
          reset = 1'b0;
        end
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rec_auto_cmd_gen.md
Name: rec_auto_cmd_gen

Overview:
- Consumer of the rec_data_sel code issued by the flight-mode controller.
- Sits between the receiver decoder and the angle controller.
- Selects, per mode, either registered raw stick values or internally generated commands: throttle ramps for auto take-off and auto-land, and a hold at hover throttle.
- Attitude sticks are forced to centre in every automatic mode.

Parameters:
- HOVER_THROTTLE, 8'd140, throttle target for take-off completion and for hover hold.
- STICK_CENTER, 8'd125, neutral value driven on yaw, roll and pitch when not passing through.
- RAMP_TICK_US, 10000, number of us_clk cycles per ramp step (10 ms).
- RAMP_STEP, 8'd1, throttle change applied per tick.
- SLEW_MAX, 8'd4, per-tick throttle slew limit. Used only when the optional feature is compiled in.

Ports:
- us_clk  in  1  1 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- rec_data_sel  in  3  mode select: 0 OFF, 1 PASS_THROUGH, 2 AUTO_TAKE_OFF, 3 HOVER, 4 AUTO_LAND. Codes 5-7 are invalid.
- rx_throttle_val  in  8  raw throttle from the receiver.
- rx_yaw_val  in  8  raw yaw from the receiver.
- rx_roll_val  in  8  raw roll from the receiver.
- rx_pitch_val  in  8  raw pitch from the receiver.
- throttle_val  out  8  commanded throttle.
- yaw_val  out  8  commanded yaw.
- roll_val  out  8  commanded roll.
- pitch_val  out  8  commanded pitch.
- auto_active  out  1  high in TAKEOFF, HOVER and LAND.
- takeoff_done  out  1  high while in TAKEOFF with throttle_val == HOVER_THROTTLE.
- land_done  out  1  high while in LAND with throttle_val == 0.
- sel_err  out  1  sticky; set by an invalid select code.

Behaviour:
- Reset (asynchronous, any time, including mid-ramp):
  - state = OFF, throttle_val = 0, yaw_val/roll_val/pitch_val = STICK_CENTER.
  - Tick counter = 0; auto_active, takeoff_done, land_done, sel_err = 0.
- State update:
  - state is reloaded from rec_data_sel every cycle.
  - Outputs reflect a new select one us_clk cycle after it is applied.
  - Codes 5-7 map to OFF and set sel_err, which stays set until reset.
- Tick prescaler:
  - Counts 0..RAMP_TICK_US-1 and pulses tick on the terminal count.
  - Cleared on every state change, so the first ramp step lands exactly RAMP_TICK_US cycles after entry.
- OFF: throttle 0; attitude outputs at STICK_CENTER.
- PASS: all four outputs register the rx_* inputs (1-cycle latency).
- TAKEOFF:
  - Ramp starts from the current throttle_val (bumpless; no jump on entry).
  - Each tick: throttle_val = min(throttle_val + RAMP_STEP, HOVER_THROTTLE). Computed 9-bit, so there is no wrap.
  - Once at HOVER_THROTTLE it holds there.
- HOVER: each tick throttle_val moves RAMP_STEP toward HOVER_THROTTLE (up or down) and never overshoots the target.
- LAND:
  - Each tick: throttle_val = (throttle_val > RAMP_STEP) ? throttle_val - RAMP_STEP : 0. Saturates at 0; no underflow.
- Attitude outputs are STICK_CENTER in TAKEOFF, HOVER, LAND and OFF.
- Simultaneous events:
  - If the select changes on the same cycle a tick would fire, the state change wins: no step is applied and the prescaler clears.
  - Re-entering the same auto mode after a different mode restarts the tick interval.
- Flags are registered and combinationally consistent with the current state and throttle_val; no extra cycle of delay.

Optional Feature:
- Macro: REC_AUTO_PASS_SLEW_EN.
- Defined:
  - In PASS, throttle_val moves toward rx_throttle_val by at most SLEW_MAX per tick.
  - Attitude outputs still pass through directly with 1-cycle latency.
- Undefined: PASS throttle is a direct 1-cycle registered copy; SLEW_MAX is unused.

Test Plan:
- Reset check: assert reset while in LAND with throttle 60 -> same cycle throttle_val 0, yaw/roll/pitch 125, sel_err 0. Release reset with sel=0 -> values hold.
- Pass-through: RAMP_TICK_US=4, sel=1, rx = 90/10/200/33 -> next cycle outputs 90/10/200/33; auto_active 0.
- Take-off ramp: RAMP_TICK_US=4, enter sel=2 from PASS with throttle 135 ->
  - throttle 136 at entry+4 cycles, 140 at entry+20;
  - takeoff_done rises with 140 and throttle stays 140 at entry+40.
- Land ramp: RAMP_STEP=3, enter sel=4 at throttle 7 -> 4 after 1 tick, 1 after 2 ticks, 0 after 3 ticks; land_done 1 and no wrap after 10 ticks.
- Hover convergence and invalid code:
  - sel=3 from throttle 150 -> decreases to 140 and stops.
  - Then sel=6 -> throttle 0, attitude 125, sel_err stays 1 after sel=1.
- Slew feature (REC_AUTO_PASS_SLEW_EN, SLEW_MAX=4, RAMP_TICK_US=4): sel=1, throttle 0, rx_throttle 20 -> 4,8,12,16,20 on successive ticks. With the macro undefined -> 20 after 1 cycle.
